// File: rtl/morra_player_driver.sv
// Stimulus/opponent block for the Morra Cinese game FSM: starts a match, emits legal
// pseudo-random move pairs, tracks round winners and keeps per-outcome match counters.
module morra_player_driver #(
  parameter int unsigned ROUND_LAT  = 1,
  parameter int unsigned MAX_CYCLES = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [3:0]       rounds_cfg,
  input  logic [7:0]       seed,
  input  logic [1:0]       ROUND,
  input  logic [1:0]       GAME,
  output logic [1:0]       P1,
  output logic [1:0]       P2,
  output logic             START,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic             timeout,
  output logic [CNT_W-1:0] wins1,
  output logic [CNT_W-1:0] wins2,
  output logic [CNT_W-1:0] draws
);

  localparam int unsigned WdW     = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [7:0]  LfsrRst = 8'hA5;

  typedef enum logic [2:0] {StIdle, StInit0, StInit1, StPlay, StDone} state_e;

  state_e                    state_q;
  logic [7:0]                lfsr_q;
  logic [WdW-1:0]            wd_q;
  logic [1:0]                lw_q;   // last round winner: 00 none, 01 P1, 10 P2
  logic [1:0]                lm_q;   // winning move of that round
  logic [ROUND_LAT-1:0][3:0] hist_q; // {P1, P2} pairs awaiting their ROUND code

  logic [7:0] lfsr_nxt;
  logic [1:0] raw1, raw2, lw_eff, lm_eff, mv1, mv2;
  logic [3:0] hist_pair;

  function automatic logic [1:0] rotate(input logic [1:0] m);
    unique case (m)
      2'b01:   rotate = 2'b10;
      2'b10:   rotate = 2'b11;
      default: rotate = 2'b01;
    endcase
  endfunction

  always_comb begin
    lfsr_nxt  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    raw1      = (lfsr_q[1:0] == 2'b00) ? 2'b01 : lfsr_q[1:0];
    raw2      = (lfsr_q[3:2] == 2'b00) ? 2'b01 : lfsr_q[3:2];
    hist_pair = hist_q[ROUND_LAT-1];
    lw_eff    = lw_q;
    lm_eff    = lm_q;
    // A round result landing this cycle already restricts the move launched at this edge.
    if (state_q == StPlay) begin
      unique case (ROUND)
        2'b01: begin
          lw_eff = 2'b01;
          lm_eff = hist_pair[3:2];
        end
        2'b10: begin
          lw_eff = 2'b10;
          lm_eff = hist_pair[1:0];
        end
        2'b11: begin
          lw_eff = 2'b00;
          lm_eff = 2'b00;
        end
        default: ;
      endcase
    end
    mv1 = (lw_eff == 2'b01 && raw1 == lm_eff) ? rotate(raw1) : raw1;
    mv2 = (lw_eff == 2'b10 && raw2 == lm_eff) ? rotate(raw2) : raw2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      P1      <= 2'b00;
      P2      <= 2'b00;
      START   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 2'b00;
      timeout <= 1'b0;
      wins1   <= '0;
      wins2   <= '0;
      draws   <= '0;
      lfsr_q  <= LfsrRst;
      lw_q    <= 2'b00;
      lm_q    <= 2'b00;
      wd_q    <= '0;
      hist_q  <= '0;
    end else begin
      hist_q[0] <= {P1, P2};
      for (int i = 1; i < ROUND_LAT; i++) hist_q[i] <= hist_q[i-1];

      unique case (state_q)
        StIdle: begin
          P1    <= 2'b00;
          P2    <= 2'b00;
          START <= 1'b0;
          if (go) begin
            lfsr_q  <= (seed == 8'h00) ? LfsrRst : seed;
            timeout <= 1'b0;
            busy    <= 1'b1;
            START   <= 1'b1;
            P1      <= rounds_cfg[3:2];
            P2      <= rounds_cfg[1:0];
            state_q <= StInit0;
          end
        end
        StInit0: begin
          // P1/P2 keep the round limit: the game re-samples it after START drops.
          START   <= 1'b0;
          state_q <= StInit1;
        end
        StInit1: begin
          lw_q    <= 2'b00;
          lm_q    <= 2'b00;
          wd_q    <= '0;
          P1      <= raw1;
          P2      <= raw2;
          lfsr_q  <= lfsr_nxt;
          state_q <= StPlay;
        end
        StPlay: begin
          wd_q   <= wd_q + 1'b1;
          lw_q   <= lw_eff;
          lm_q   <= lm_eff;
          lfsr_q <= lfsr_nxt;
          P1     <= mv1;
          P2     <= mv2;
          if (GAME != 2'b00 || wd_q == WdW'(MAX_CYCLES - 1)) begin
            P1      <= 2'b00;
            P2      <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= GAME;
            state_q <= StDone;
            if (GAME == 2'b00) timeout <= 1'b1;
            if (GAME == 2'b01 && wins1 != '1) wins1 <= wins1 + CNT_W'(1);
            if (GAME == 2'b10 && wins2 != '1) wins2 <= wins2 + CNT_W'(1);
            if (GAME == 2'b11 && draws != '1) draws <= draws + CNT_W'(1);
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_morra_player_driver.sv
// Directed bench for morra_player_driver: start protocol, move legality, completion,
// watchdog abort, mid-match reset and counter saturation.
module tb_morra_player_driver;

  logic       clk = 1'b0;
  logic       rst, go;
  logic [3:0] rounds_cfg;
  logic [7:0] seed;
  logic [1:0] ROUND, GAME;
  logic [1:0] P1, P2, result;
  logic       START, busy, done, timeout;
  logic [7:0] wins1, wins2, draws;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  morra_player_driver #(
    .ROUND_LAT (1),
    .MAX_CYCLES(64),
    .CNT_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .rounds_cfg(rounds_cfg),
    .seed      (seed),
    .ROUND     (ROUND),
    .GAME      (GAME),
    .P1        (P1),
    .P2        (P2),
    .START     (START),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .timeout   (timeout),
    .wins1     (wins1),
    .wins2     (wins2),
    .draws     (draws)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [1:0] map_move(input logic [1:0] r);
    return (r == 2'b00) ? 2'b01 : r;
  endfunction

  initial begin
    logic [7:0] m;
    int bad, n_done;
    logic got_done;

    // Reset with go asserted alongside it
    rst = 1'b1; go = 1'b1; rounds_cfg = 4'h0; seed = 8'h00; ROUND = 2'b00; GAME = 2'b00;
    repeat (3) step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_start", START, 1'b0);
    rst = 1'b0; go = 1'b0;
    step();
    check_eq("idle_p1", P1, 2'b00);
    check_eq("idle_p2", P2, 2'b00);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_done", done, 1'b0);
    check_eq("idle_result", result, 2'b00);
    check_eq("idle_timeout", timeout, 1'b0);
    check_eq("idle_cnts", {wins1, wins2, draws}, 24'h0);

    // Start protocol, then let the watchdog expire with GAME held at 00
    rounds_cfg = 4'b0110; seed = 8'h3C; go = 1'b1;
    step();
    go = 1'b0;
    check_eq("init0_start", START, 1'b1);
    check_eq("init0_p1", P1, 2'b01);
    check_eq("init0_p2", P2, 2'b10);
    check_eq("init0_busy", busy, 1'b1);
    step();
    check_eq("init1_start", START, 1'b0);
    check_eq("init1_pair", {P1, P2}, 4'b0110);
    step();
    check_eq("play0_busy", busy, 1'b1);
    check_eq("play0_p1", P1, 2'b01);
    check_eq("play0_p2", P2, 2'b11);
    m = 8'h3C; bad = 0;
    for (int k = 0; k < 64; k++) begin
      if (P1 !== map_move(m[1:0]) || P2 !== map_move(m[3:2]) || busy !== 1'b1 || done !== 1'b0)
        bad++;
      m = lfsr_next(m);
      step();
    end
    check_eq("wd_play_cycles", bad, 0);
    check_eq("wd_done", done, 1'b1);
    check_eq("wd_timeout", timeout, 1'b1);
    check_eq("wd_result", result, 2'b00);
    check_eq("wd_busy", busy, 1'b0);
    check_eq("wd_pair", {P1, P2}, 4'b0000);
    check_eq("wd_cnts", {wins1, wins2, draws}, 24'h0);

    // go held in DONE: accepted only from IDLE; legality and completion match
    rounds_cfg = 4'b1001; seed = 8'h3A; go = 1'b1;
    step();
    check_eq("done_go_busy", busy, 1'b0);
    check_eq("done_go_start", START, 1'b0);
    check_eq("done_go_done", done, 1'b0);
    check_eq("sticky_timeout", timeout, 1'b1);
    step();
    go = 1'b0;
    check_eq("m2_init0_start", START, 1'b1);
    check_eq("m2_init0_pair", {P1, P2}, 4'b1001);
    check_eq("m2_timeout_clr", timeout, 1'b0);
    step();
    step();
    check_eq("m2_play0", {P1, P2}, 4'b1010);
    step();
    check_eq("m2_play1", {P1, P2}, 4'b0101);
    ROUND = 2'b01;  // P1 won with paper in play0
    step();
    check_eq("m2_rotated", {P1, P2}, 4'b1110);
    ROUND = 2'b00;
    step();
    check_eq("m2_play3", {P1, P2}, 4'b0101);
    ROUND = 2'b11;  // tie clears the restriction
    step();
    check_eq("m2_unrestricted", {P1, P2}, 4'b1010);
    ROUND = 2'b10; GAME = 2'b10;
    step();
    ROUND = 2'b00; GAME = 2'b00;
    check_eq("m2_done", done, 1'b1);
    check_eq("m2_result", result, 2'b10);
    check_eq("m2_wins2", wins2, 8'd1);
    check_eq("m2_busy", busy, 1'b0);
    check_eq("m2_pair", {P1, P2}, 4'b0000);
    step();
    check_eq("m2_done_pulse", done, 1'b0);
    check_eq("m2_idle_busy", busy, 1'b0);

    // Seed 00 loads A5; reset during PLAY aborts silently
    seed = 8'h00; go = 1'b1;
    step();
    go = 1'b0;
    step();
    step();
    check_eq("s0_play0", {P1, P2}, 4'b0101);
    step();
    check_eq("s0_play1", {P1, P2}, 4'b1010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_pair", {P1, P2}, 4'b0000);
    check_eq("mrst_result", result, 2'b00);
    check_eq("mrst_wins2", wins2, 8'd0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    check_eq("mrst_quiet", bad, 0);

    // Back-to-back P1 wins until wins1 saturates
    go = 1'b1; GAME = 2'b01; n_done = 0;
    for (int k = 0; k < 2000 && n_done < 260; k++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    check_eq("sat_matches", n_done, 260);
    check_eq("sat_wins1", wins1, 8'hFF);
    check_eq("sat_others", {wins2, draws}, 16'h0);
    GAME = 2'b11; got_done = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      step();
      if (done === 1'b1) got_done = 1'b1;
    end
    go = 1'b0; GAME = 2'b00;
    check_eq("draw_done", got_done, 1'b1);
    check_eq("draw_result", result, 2'b11);
    check_eq("draw_cnt", draws, 8'd1);
    check_eq("draw_wins1", wins1, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/morra_player_driver.md
Name: morra_player_driver

Overview:
- Stimulus and opponent block for the Morra Cinese game FSM. It drives the game's P1, P2 and START inputs and consumes its ROUND and GAME outputs.
- It starts a match, encodes the configured round limit, and generates legal pseudo-random moves for both players every cycle.
- It tracks round winners so that it never emits a move the game would void, and latches the final GAME result.
- Per-outcome match counters are kept for system-level soak testing.

Parameters:
- ROUND_LAT, 1: cycles between presenting a move pair on P1/P2 and the corresponding ROUND code arriving.
- MAX_CYCLES, 64: PLAY-state watchdog limit in cycles. On expiry the match is aborted.
- CNT_W, 8: width of the match counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  request a new match. Sampled in IDLE only.
- rounds_cfg  in  4  round-limit code. The game plays up to rounds_cfg+4 rounds (4..19).
- seed  in  8  LFSR seed, loaded on an accepted go.
- ROUND  in  2  game round result: 00 void/none, 01 P1 wins, 10 P2 wins, 11 tie.
- GAME  in  2  game result: 00 in progress, 01 P1, 10 P2, 11 draw.
- P1  out  2  player-1 move: 01 rock, 10 paper, 11 scissors, 00 no move.
- P2  out  2  player-2 move, same encoding as P1.
- START  out  1  game restart strobe.
- busy  out  1  high from an accepted go until done.
- done  out  1  one-cycle pulse at match end.
- result  out  2  last match GAME code. 00 means aborted.
- timeout  out  1  sticky flag set on watchdog abort. Cleared by the next accepted go.
- wins1, wins2, draws  out  CNT_W  completed-match counters.

Behaviour:
- Reset: rst is sampled on the clk rising edge. It forces the following values, and overrides go in the same cycle:
  - state = IDLE.
  - P1 = P2 = 00, START = 0, busy = 0, done = 0.
  - result = 00, timeout = 0.
  - counters = 0.
  - LFSR = 8'hA5, last_winner = none, last_move = 00, watchdog = 0.
- rst asserted mid-match aborts the match silently: no done pulse and no counter update.
- FSM states:
  - IDLE: P1 = P2 = 00, START = 0. On go, capture cfg = rounds_cfg, load the LFSR with seed (seed 8'h00 loads 8'hA5), clear timeout, assert busy, go to INIT0.
  - INIT0 (1 cycle): START = 1, P1 = cfg[3:2], P2 = cfg[1:0]. Go to INIT1.
  - INIT1 (1 cycle): START = 0. P1/P2 still carry cfg, because the game re-samples the limit in its first post-start state. Clear last_winner and the watchdog. Go to PLAY.
  - PLAY: present a new move pair every cycle (see move generation). Increment the watchdog each cycle.
    - If GAME != 00: result = GAME, increment the matching counter (01 → wins1, 10 → wins2, 11 → draws), go to DONE.
    - Else if watchdog == MAX_CYCLES-1: result = 00, timeout = 1, no counter update, go to DONE.
  - DONE (1 cycle): done = 1, busy = 0, P1 = P2 = 00. Go to IDLE.
- A go asserted while busy is ignored. A go held high in DONE is not accepted until IDLE, the next cycle.
- Move generation:
  - LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Steps once per PLAY cycle.
  - Raw candidates: c1 = lfsr[1:0], c2 = lfsr[3:2]. A raw value of 00 maps to 01, so 00 is never emitted in PLAY.
  - Legality: if last_winner = P1 and c1 == last_move, rotate c1 (01→10→11→01). The same rule applies to P2 with c2. The rotated value is emitted. Outputs P1/P2 are registered.
- Winner tracking:
  - A history pipe of depth ROUND_LAT holds the emitted pairs.
  - When ROUND arrives it is matched with the pair emitted ROUND_LAT cycles earlier:
    - 01: last_winner = P1, last_move = that P1.
    - 10: last_winner = P2, last_move = that P2.
    - 11: clear last_winner and last_move.
    - 00: no change.
  - If a ROUND update and move generation fall in the same cycle, the update applies first. The new restriction constrains the move emitted at the next edge.
- Counters: saturate at all-ones; they never wrap.

Test Plan:
- Reset check: rst held 3 cycles, then released → all outputs at their reset values, IDLE. A go asserted together with rst is ignored.
- Start protocol: go with rounds_cfg = 4'b0110, seed = 8'h3C → INIT0 shows START = 1, P1 = 01, P2 = 10. INIT1 shows START = 0 with the same P1/P2. PLAY then begins with busy = 1.
- Legality: model ROUND = 01 returned for a pair with P1 = 10, with the next raw c1 forced to 10 → emitted P1 = 11. A subsequent ROUND = 11 → restriction cleared, raw 10 is emitted unchanged.
- Completion: game model returns GAME = 10 after 5 rounds → result = 10, wins2 = 1, single-cycle done, busy low, P1 = P2 = 00 next cycle.
- Watchdog: GAME held at 00 → after 64 PLAY cycles, timeout = 1, result = 00, done pulses, counters unchanged.
- Mid-match rst during PLAY, then 255+ back-to-back P1 wins → no done pulse on the reset, outputs return to reset values; wins1 saturates at 8'hFF.
